// File: rtl/serial_pkg.sv
// serial_pkg: frame state encoding shared by the serial transmitter and receiver
package serial_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts clk cycles within one serial bit and ticks bit_done on the last one
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic bit_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt;
    assign bit_done = en && cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else if (en) cnt <= bit_done ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/serial_tx_piso.sv
// serial_tx_piso: parallel-in serial-out transmitter framing each word as start, LSB-first data, stop
module serial_tx_piso
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic             ready,
    output logic             q,
    output logic             busy
);
    localparam int IW = $clog2(WIDTH);
    tx_state_t      state;
    logic [WIDTH-1:0] sr;
    logic [IW-1:0]  idx;
    logic           transfer;
    logic           bit_done;
    logic           last;
    assign transfer = valid && ready;
    assign last     = idx == IW'(WIDTH - 1);
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clear(transfer),
        .en(busy),
        .bit_done(bit_done)
    );
    // q is loaded one state ahead so it always reflects the bit of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            sr    <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: if (transfer) begin
                    state <= START;
                    sr    <= d;
                    q     <= 1'b0;
                    ready <= 1'b0;
                    busy  <= 1'b1;
                end
                START: if (bit_done) begin
                    state <= DATA;
                    q     <= sr[0];
                end
                DATA: if (bit_done) begin
                    state <= last ? STOP : DATA;
                    sr    <= sr >> 1;
                    idx   <= last ? '0 : idx + 1'b1;
                    q     <= last ? 1'b1 : sr[1];
                end
                STOP: if (bit_done) begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_piso.sv
// tb_serial_tx_piso: directed and random frames on a 4-clock-per-bit and a 1-clock-per-bit transmitter
module tb_serial_tx_piso;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] d = '0;
    logic         q_a, ready_a, busy_a, q_b, ready_b, busy_b;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    serial_tx_piso #(.WIDTH(W), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .d(d), .valid(valid & ~sel),
        .ready(ready_a), .q(q_a), .busy(busy_a)
    );
    serial_tx_piso #(.WIDTH(W), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .d(d), .valid(valid & sel),
        .ready(ready_b), .q(q_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic eq, input logic er, input logic eb);
        chk({tag, "_q"}, sel ? q_b : q_a, eq);
        chk({tag, "_ready"}, sel ? ready_b : ready_a, er);
        chk({tag, "_busy"}, sel ? busy_b : busy_a, eb);
    endtask

    // line level k cycles after the transfer edge: start bit, data LSB first, stop bit
    function automatic logic exp_bit(input logic [W-1:0] w, input int k, input int c);
        int b;
        b = k / c;
        return b == 0 ? 1'b0 : (b <= W ? w[b-1] : 1'b1);
    endfunction

    // mode 0: valid dropped; 1: random d/valid during frame; 2: valid held with next word nd
    task automatic run_frame(input logic [W-1:0] w, input int mode, input logic [W-1:0] nd, input int abort_k);
        int c;
        int len;
        c = sel ? 1 : 4;
        len = (W + 2) * c;
        d = w;
        valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < len; k++) begin
            check_out($sformatf("w%02h_c%0d", w, k), exp_bit(w, k, c), 1'b0, 1'b1);
            if (k == abort_k) begin
                valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_out("abort", 1'b1, 1'b1, 1'b0);
                for (int j = 0; j < len; j++) begin
                    @(negedge clk);
                    check_out($sformatf("post_abort%0d", j), 1'b1, 1'b1, 1'b0);
                end
                return;
            end
            if (mode == 0) valid = 1'b0;
            else if (mode == 1) begin
                d = W'($urandom);
                valid = (k < len - 1) ? 1'($urandom) : 1'b0;
            end else begin
                d = nd;
                valid = 1'b1;
            end
            @(negedge clk);
        end
        check_out($sformatf("w%02h_idle", w), 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        d = W'($urandom);
        valid = 1'b1;
        @(negedge clk);
        check_out("rst1", 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_out("rst2", 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        check_out("idle", 1'b1, 1'b1, 1'b0);
        run_frame(8'hA5, 0, 8'h00, -1);
        run_frame(8'h00, 2, 8'hFF, -1);
        run_frame(8'hFF, 0, 8'h00, -1);
        run_frame(8'h3C, 1, 8'h00, -1);
        run_frame(8'h55, 0, 8'h00, (1 + 3) * 4 + 1);
        for (int i = 0; i < 6; i++) run_frame(W'($urandom), int'($urandom_range(0, 1)), 8'h00, -1);
        sel = 1'b1;
        @(negedge clk);
        check_out("sel_b_idle", 1'b1, 1'b1, 1'b0);
        run_frame(8'h81, 0, 8'h00, -1);
        run_frame(8'h5A, 2, 8'hC3, -1);
        run_frame(8'hC3, 0, 8'h00, -1);
        run_frame(8'h96, 0, 8'h00, 4);
        for (int i = 0; i < 6; i++) run_frame(W'($urandom), int'($urandom_range(0, 1)), 8'h00, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_tx_piso.md
SERIAL_TX_PISO -- requirements
Module: serial_tx_piso

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (WIDTH >= 2).
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (CLKS_PER_BIT >= 1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 d  input  WIDTH  parallel word to transmit.
REQ-006 valid  input  1  d is valid; request to transmit.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 q  output  1  serial line out; idle level 1.
REQ-009 busy  output  1  frame in progress.

Function
REQ-010 Transfer occurs on a rising edge where valid=1 and ready=1; d is captured into an internal shift register at that edge.
REQ-011 ready=1 only in IDLE; ready=0 in all other states.
REQ-012 FSM states: IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on transfer; START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after WIDTH bits of CLKS_PER_BIT cycles each; STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-014 q=1 in IDLE, q=0 in START, q=current shift-register LSB in DATA, q=1 in STOP; q registered, no combinational path from d or valid.
REQ-015 Data bits sent LSB first; shift register shifts right by one at end of each DATA bit period.
REQ-016 q changes to start bit in the first cycle after the transfer edge; frame length exactly (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-017 busy=1 in START, DATA, STOP; busy=0 in IDLE.
REQ-018 Changes to d or valid while busy=1 are ignored; captured word unaffected.
REQ-019 Back-to-back: with valid held at 1, next transfer occurs on the first edge in IDLE; exactly one idle cycle (q=1) between stop bit and next start bit.
REQ-020 Bit-period counter width = max(1, clog2(CLKS_PER_BIT)); bit-index counter width = clog2(WIDTH); both wrap to 0 at terminal count, never overflow.
REQ-021 CLKS_PER_BIT=1: each bit lasts exactly one cycle; FSM shall not stall or skip bits.
REQ-022 valid=1 with rst=1 on the same edge: reset wins; no transfer.

Reset
REQ-023 On rst=1: state=IDLE, q=1, ready=1, busy=0, shift register=0, all counters=0, effective next edge.
REQ-024 rst asserted mid-frame aborts the frame; q=1 from the cycle after the reset edge; aborted word is discarded and not resent.

Structure
REQ-025 State encoding localparams (IDLE, START, DATA, STOP) belong in shared package serial_pkg, reused by the future receiver.
REQ-026 One sub-module, bit_timer: counts 0..CLKS_PER_BIT-1 and emits a one-cycle bit_done tick; cleared by rst and on transfer.
REQ-027 All other logic (FSM, shift register, bit index, outputs) in serial_tx_piso.

Verification
REQ-028 Reset: rst=1 two cycles, mid-frame and idle -> q=1, ready=1, busy=0 cycle after reset edge.
REQ-029 Single frame: WIDTH=8, CLKS_PER_BIT=4, d=8'hA5, valid pulse -> q = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total, then ready=1.
REQ-030 Back-to-back: valid held 1, d=8'h00 then 8'hFF -> two frames separated by exactly one q=1 idle cycle; second frame data bits all 1.
REQ-031 Ignore-while-busy: after accepting 8'h3C, drive d=8'hFF, valid=1 during frame -> transmitted bits still 0,0,1,1,1,1,0,0.
REQ-032 Abort: rst=1 during DATA bit 3 of 8'h55 -> q=1 next cycle, ready=1, no remaining bits or stop emitted.
REQ-033 CLKS_PER_BIT=1, d=8'h81 -> q = 0,1,0,0,0,0,0,0,1,1 on 10 consecutive cycles.
